// File: rtl/pulse_expand.sv
// pulse_expand: turns counted event totals back into single-cycle pulses.
// Accepted counts accumulate in acc_reg; every enabled cycle up to
// OUTPUT_WIDTH events drain out as a thermometer-coded pulse vector.
module pulse_expand #(
  parameter int OUTPUT_WIDTH = 2,
  parameter int COUNT_WIDTH  = 4,
  parameter int ACC_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COUNT_WIDTH-1:0]  in_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    pulse_enable,
  output logic [OUTPUT_WIDTH-1:0] pulse_out,
  output logic [ACC_WIDTH-1:0]    pending_out,
  output logic                    idle
);

  // Limits are held one bit wider than the accumulator so the ready
  // threshold (MAXACC - MAXIN) never wraps.
  localparam logic [ACC_WIDTH:0]   MAX_ACC     = {1'b0, {ACC_WIDTH{1'b1}}};
  localparam logic [ACC_WIDTH:0]   MAX_IN      = (ACC_WIDTH+1)'({COUNT_WIDTH{1'b1}});
  localparam logic [ACC_WIDTH:0]   READY_LIMIT = MAX_ACC - MAX_IN;
  localparam logic [ACC_WIDTH-1:0] LANES       = ACC_WIDTH'(OUTPUT_WIDTH);

  // Clamp the pending count to the number of pulse lanes.
  function automatic logic [ACC_WIDTH-1:0] sat_lanes(input logic [ACC_WIDTH-1:0] avail);
    return (avail < LANES) ? avail : LANES;
  endfunction

  // Thermometer encode: lanes [n-1:0] high.
  function automatic logic [OUTPUT_WIDTH-1:0] thermo(input logic [ACC_WIDTH-1:0] n);
    logic [OUTPUT_WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
      t[i] = (ACC_WIDTH'(i) < n);
    end
    return t;
  endfunction

  logic [ACC_WIDTH-1:0]    acc_reg;
  logic [OUTPUT_WIDTH-1:0] pulse_reg;
  logic                    accept;
  logic [ACC_WIDTH-1:0]    emit_n;
  logic [ACC_WIDTH:0]      add_w;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic [OUTPUT_WIDTH-1:0] pulse_next;

  // ---- stage p0: decisions from registered state and current inputs ----

  // Ready depends only on the accumulator so upstream never sees a
  // combinational path from its own valid.
  assign in_ready = ({1'b0, acc_reg} <= READY_LIMIT);

  // Emit and accept in the same cycle; the sum is formed one bit wide and
  // the ready rule keeps it within the accumulator range.
  always_comb begin
    accept     = in_valid & in_ready;
    emit_n     = pulse_enable ? sat_lanes(acc_reg) : '0;
    add_w      = accept ? (ACC_WIDTH+1)'(in_count) : '0;
    acc_next   = ACC_WIDTH'({1'b0, acc_reg} - {1'b0, emit_n} + add_w);
    pulse_next = thermo(emit_n);
  end

  // ---- stage p1: registered accumulator and pulse lanes ----

  // Reset discards all pending events and any in-flight pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      pulse_reg <= '0;
    end else begin
      acc_reg   <= acc_next;
      pulse_reg <= pulse_next;
    end
  end

  assign pulse_out   = pulse_reg;
  assign pending_out = acc_reg;
  assign idle        = (acc_reg == '0) && (pulse_reg == '0);

endmodule

// File: tb/tb_pulse_expand.sv
// Self-checking bench for pulse_expand at default parameters.
module tb_pulse_expand;
  localparam int OW = 2;
  localparam int CW = 4;
  localparam int AW = 8;
  localparam int MAXIN = 15;
  localparam int MAXACC = 255;
  localparam int LIMIT = MAXACC - MAXIN;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] in_count;
  logic          in_valid;
  logic          in_ready;
  logic          pulse_enable;
  logic [OW-1:0] pulse_out;
  logic [AW-1:0] pending_out;
  logic          idle;

  int total = 0;
  int bad = 0;

  pulse_expand #(.OUTPUT_WIDTH(OW), .COUNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready), .pulse_enable(pulse_enable), .pulse_out(pulse_out),
    .pending_out(pending_out), .idle(idle)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_single();
    logic [OW-1:0] exp_p [0:2];
    exp_p[0] = 2'b11; exp_p[1] = 2'b11; exp_p[2] = 2'b01;
    pulse_enable = 1'b1;
    do_reset();
    total++; if (pulse_out !== 2'b00) begin bad++; $display("FAIL rst_pulse got=%b want=00", pulse_out); end
    total++; if (pending_out !== 8'd0) begin bad++; $display("FAIL rst_pending got=%0d want=0", pending_out); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b want=1", idle); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
    in_valid = 1'b1; in_count = 4'd5;
    tick();
    in_valid = 1'b0; in_count = '0;
    total++; if (pending_out !== 8'd5) begin bad++; $display("FAIL single_pending1 got=%0d want=5", pending_out); end
    total++; if (pulse_out !== 2'b00) begin bad++; $display("FAIL single_pulse1 got=%b want=00", pulse_out); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (pulse_out !== exp_p[c]) begin
        bad++; $display("FAIL single_pulse cycle=%0d got=%b want=%b", c + 2, pulse_out, exp_p[c]);
      end
    end
    tick();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle5 got=%b want=1", idle); end
    total++; if (pulse_out !== 2'b00) begin bad++; $display("FAIL single_pulse5 got=%b want=00", pulse_out); end
  endtask

  task automatic test_back_to_back();
    int seen;
    int started;
    int gap;
    int bigs;
    int nonthermo;
    seen = 0; started = 0; gap = 0; bigs = 0; nonthermo = 0;
    pulse_enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c < 3);
      in_count = (c < 3) ? 4'd3 : 4'd0;
      tick();
      if (pulse_out != 0) started = 1;
      else if (started != 0 && seen < 9) gap++;
      if ($countones(pulse_out) > OW) bigs++;
      if (pulse_out != 2'b00 && pulse_out != 2'b01 && pulse_out != 2'b11) nonthermo++;
      seen += $countones(pulse_out);
    end
    in_valid = 1'b0;
    total++; if (seen !== 9) begin bad++; $display("FAIL b2b_total got=%0d want=9", seen); end
    total++; if (gap !== 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gap); end
    total++; if (bigs + nonthermo !== 0) begin bad++; $display("FAIL b2b_shape got=%0d want=0", bigs + nonthermo); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", idle); end
  endtask

  task automatic test_enable_gating();
    pulse_enable = 1'b0;
    in_valid = 1'b1; in_count = 4'd4;
    tick();
    in_valid = 1'b0; in_count = '0;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (pulse_out !== 2'b00 || pending_out !== 8'd4) begin
        bad++; $display("FAIL gate_hold cycle=%0d got=%b/%0d want=00/4", c, pulse_out, pending_out);
      end
      tick();
    end
    pulse_enable = 1'b1;
    tick();
    total++; if (pulse_out !== 2'b11 || pending_out !== 8'd2) begin bad++; $display("FAIL gate_first got=%b/%0d want=11/2", pulse_out, pending_out); end
    tick();
    total++; if (pulse_out !== 2'b11 || pending_out !== 8'd0) begin bad++; $display("FAIL gate_second got=%b/%0d want=11/0", pulse_out, pending_out); end
    tick();
    total++; if (pulse_out !== 2'b00 || idle !== 1'b1) begin bad++; $display("FAIL gate_done got=%b/%b want=00/1", pulse_out, idle); end
  endtask

  task automatic test_backpressure();
    int accepts;
    int prev;
    int drained;
    accepts = 0;
    pulse_enable = 1'b0;
    in_valid = 1'b1; in_count = 4'd15;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (in_ready !== ((accepts * 15) <= LIMIT)) begin
        bad++; $display("FAIL bp_ready cycle=%0d got=%b want=%b", c, in_ready, (accepts * 15) <= LIMIT);
      end
      if (in_ready === 1'b1) accepts++;
      tick();
    end
    in_valid = 1'b0; in_count = '0;
    total++; if (accepts !== 17) begin bad++; $display("FAIL bp_accepts got=%0d want=17", accepts); end
    total++; if (pending_out !== 8'd255) begin bad++; $display("FAIL bp_full got=%0d want=255", pending_out); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
    pulse_enable = 1'b1;
    prev = 255;
    drained = 0;
    for (int c = 0; c < 200 && drained == 0; c++) begin
      tick();
      total++;
      if (int'(pending_out) !== ((prev >= 2) ? prev - 2 : 0) || in_ready !== (int'(pending_out) <= LIMIT)) begin
        bad++; $display("FAIL bp_drain cycle=%0d got=%0d/%b want=%0d", c, pending_out, in_ready, (prev >= 2) ? prev - 2 : 0);
      end
      prev = int'(pending_out);
      if (idle === 1'b1) drained = 1;
    end
    total++; if (drained !== 1) begin bad++; $display("FAIL bp_drain_timeout got=%0d want=1", drained); end
  endtask

  task automatic test_zero_and_reset();
    pulse_enable = 1'b1;
    in_valid = 1'b1; in_count = 4'd0;
    tick();
    in_valid = 1'b0;
    total++; if (pending_out !== 8'd0 || idle !== 1'b1) begin bad++; $display("FAIL zero_pending got=%0d/%b want=0/1", pending_out, idle); end
    tick();
    total++; if (pulse_out !== 2'b00) begin bad++; $display("FAIL zero_pulse got=%b want=00", pulse_out); end
    in_valid = 1'b1; in_count = 4'd10;
    tick();
    in_valid = 1'b0; in_count = '0;
    total++; if (pending_out !== 8'd10) begin bad++; $display("FAIL mid_load got=%0d want=10", pending_out); end
    tick();
    total++; if (pulse_out !== 2'b11 || pending_out !== 8'd8) begin bad++; $display("FAIL mid_drain1 got=%b/%0d want=11/8", pulse_out, pending_out); end
    tick();
    total++; if (pulse_out !== 2'b11 || pending_out !== 8'd6) begin bad++; $display("FAIL mid_drain2 got=%b/%0d want=11/6", pulse_out, pending_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (pulse_out !== 2'b00 || pending_out !== 8'd0) begin bad++; $display("FAIL mid_rst got=%b/%0d want=00/0", pulse_out, pending_out); end
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (pulse_out !== 2'b00 || idle !== 1'b1) begin
        bad++; $display("FAIL post_rst cycle=%0d got=%b/%b want=00/1", c, pulse_out, idle);
      end
    end
  endtask

  // Reference: pending = accepted_total - emitted_total; each enabled cycle
  // emits min(pending, OW) events, visible on pulse_out one cycle later.
  task automatic test_random();
    longint acc_tot;
    longint emit_tot;
    longint seen_tot;
    int pend;
    int lanes;
    int nxt;
    logic [OW-1:0] exp_p;
    int quiet;
    do_reset();
    acc_tot = 0; emit_tot = 0; seen_tot = 0; lanes = 0;
    for (int c = 0; c < 10000 + 200; c++) begin
      pend = int'(acc_tot - emit_tot);
      exp_p = OW'((1 << lanes) - 1);
      total++;
      if (pulse_out !== exp_p || int'(pending_out) !== pend || in_ready !== (pend <= LIMIT)
          || idle !== (pend == 0 && lanes == 0)) begin
        bad++;
        $display("FAIL rand cycle=%0d got=%b/%0d/%b/%b want=%b/%0d/%b/%b", c, pulse_out, pending_out,
                 in_ready, idle, exp_p, pend, pend <= LIMIT, pend == 0 && lanes == 0);
      end
      seen_tot += $countones(pulse_out);
      if (c < 10000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_count = CW'($urandom_range(0, MAXIN));
        pulse_enable = ($urandom_range(0, 1) != 0);
      end else begin
        in_valid = 1'b0;
        in_count = '0;
        pulse_enable = 1'b1;
      end
      nxt = pulse_enable ? ((pend < OW) ? pend : OW) : 0;
      if (in_valid && pend <= LIMIT) acc_tot += in_count;
      emit_tot += nxt;
      lanes = nxt;
      tick();
    end
    in_valid = 1'b0;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      seen_tot += $countones(pulse_out);
      tick();
    end
    quiet = idle;
    total++; if (seen_tot !== acc_tot) begin bad++; $display("FAIL rand_conserve got=%0d want=%0d", seen_tot, acc_tot); end
    total++; if (quiet !== 1) begin bad++; $display("FAIL rand_final_idle got=%0d want=1", quiet); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    pulse_enable = 1'b0;
    test_reset_single();
    test_back_to_back();
    test_enable_gating();
    test_backpressure();
    test_zero_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pulse_expand.md
# pulse_expand

Expands counted event totals back into individual single-cycle pulses. It is the expansion counterpart of the pulse-merge counter. Upstream logic hands over a multi-bit event count through a valid/ready handshake. The block accumulates pending events and emits up to OUTPUT_WIDTH pulses per cycle on a thermometer-coded output, gated by a downstream enable. It sits between DMA/queue completion accounting and per-event consumers such as doorbell, interrupt or credit-return logic.

## Interface

- OUTPUT_WIDTH, default 2: maximum pulses emitted per cycle; number of pulse output lanes (>= 1).
- COUNT_WIDTH, default 4: width of the input event count.
- ACC_WIDTH, default 8: width of the pending-event accumulator. Must exceed COUNT_WIDTH, and 2^ACC_WIDTH-1 >= OUTPUT_WIDTH.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_count  input  COUNT_WIDTH  number of events to add; 0 is legal and has no effect.
- in_valid  input  1  in_count is valid.
- in_ready  output  1  block can accept in_count this cycle.
- pulse_enable  input  1  downstream may take pulses this cycle.
- pulse_out  output  OUTPUT_WIDTH  thermometer-coded pulses; lanes [n-1:0] high means n events emitted this cycle.
- pending_out  output  ACC_WIDTH  current accumulator value, acc_reg.
- idle  output  1  high when acc_reg == 0 and pulse_out == 0.

## Operation

- State: acc_reg (ACC_WIDTH bits) and pulse_reg (OUTPUT_WIDTH bits). pulse_out = pulse_reg, pending_out = acc_reg.
- Let MAXIN = 2^COUNT_WIDTH-1 and MAXACC = 2^ACC_WIDTH-1.
- in_ready: combinational from acc_reg only, never from in_valid. in_ready = (acc_reg <= MAXACC - MAXIN).
- accept = in_valid & in_ready.
- Emit count: n = pulse_enable ? min(acc_reg, OUTPUT_WIDTH) : 0. The min is computed at ACC_WIDTH width.
- acc_next = acc_reg - n + (accept ? in_count : 0).
  - Subtraction and addition happen in the same cycle.
  - Intermediate width must be ACC_WIDTH+1 bits. The ready rule guarantees the result never exceeds MAXACC, so no wrap-around or saturation is possible.
- pulse_next: bits [n-1:0] = 1, all others 0. n = 0 gives all zeros.
- When pulse_enable is low, no events are consumed, pulse_next = 0, and the accumulator still accepts input per in_ready.
- Simultaneous accept and emit in one cycle is the normal case. Both take effect.
- Events are conserved. Total pulses emitted equals the sum of accepted in_count, with no loss or duplication.
- Reset mid-operation: all pending events are discarded. No pulses are emitted for them afterwards.

## Timing

- Reset values: acc_reg = 0, pulse_out = 0, pending_out = 0, in_ready = 1, idle = 1.
- An accept in cycle t updates pending_out in cycle t+1.
- The first pulses for that accept appear on pulse_out in cycle t+2, provided pulse_enable is high in t+1.
- pulse_out is registered. Pulses decided from acc_reg in cycle t appear in cycle t+1.
- An isolated input count c with pulse_enable held high:
  - drains over ceil(c/OUTPUT_WIDTH) consecutive output cycles;
  - the last cycle has c mod OUTPUT_WIDTH lanes high when that value is nonzero, otherwise all lanes high.
- Throughput: sustained OUTPUT_WIDTH pulses per cycle. Input accepted every cycle while in_ready is high.
- in_ready deasserts in the cycle after acc_reg crosses above MAXACC-MAXIN. It reasserts in the cycle after the drain brings acc_reg back within the limit.
- idle is combinational from registered state. It first rises the cycle after the last pulse cycle.

## Test plan

- Reset and single count (defaults): assert rst for 2 cycles, then accept in_count=5 in cycle 0 with pulse_enable=1.
  - Outputs are 0/0/1 after reset.
  - pending_out = 5 in cycle 1.
  - pulse_out = 2'b11, 2'b11, 2'b01 in cycles 2, 3, 4.
  - idle = 1 in cycle 5.
- Back-to-back input: accept 3, 3, 3 on consecutive cycles with pulse_enable=1 → total of exactly 9 pulses, at most 2 per cycle, no gaps until drained.
- Enable gating: load 4 with pulse_enable=0 for 10 cycles → pulse_out stays 0 and pending_out stays 4. Raise enable → 2'b11, 2'b11, then 0.
- Backpressure at defaults (MAXACC=255, MAXIN=15): pulse_enable=0, then offer 15 every cycle.
  - 16 accepts bring acc to 240.
  - The 17th accept is taken (240 <= 240), giving acc = 255.
  - in_ready = 0 thereafter.
  - Enable pulses; in_ready returns once acc <= 240.
  - acc never wraps.
- in_count=0 and reset mid-drain: accept 0 → no change, no pulses. Load 10, drain two cycles, then assert rst → pulse_out = 0 and pending_out = 0 the next cycle, with no further pulses.
- Randomized conservation: random in_valid, in_count and pulse_enable for 10k cycles → sum of pulse_out popcounts equals sum of accepted counts after final drain; lanes always thermometer-coded.
